// File: rtl/pi_loop_filter_if.sv
// Sample/control bundle between the phase detector, the PI loop filter and the DCO.
// The master drives the error samples; the slave (the filter) returns the control word.
interface pi_loop_filter_if #(
    parameter int CW_WIDTH = 16
);
    logic signed [3:0]   error_in;
    logic                sample_en;
    logic                hold;
    logic [CW_WIDTH-1:0] ctrl_word;
    logic                ctrl_valid;
    logic                ctrl_sat;
    logic                locked;

    modport master (
        output error_in, sample_en, hold,
        input  ctrl_word, ctrl_valid, ctrl_sat, locked
    );

    modport slave (
        input  error_in, sample_en, hold,
        output ctrl_word, ctrl_valid, ctrl_sat, locked
    );
endinterface

// File: rtl/pi_loop_filter.sv
// Two-stage PI loop filter with lock detector that swaps acquisition/tracking gains.
// Define LF_DITHER_EN to add an LFSR-driven 1-LSB dither term to the control word.
module pi_loop_filter #(
    parameter int CW_WIDTH     = 16,
    parameter int ACC_WIDTH    = 24,
    parameter int FRAC_BITS    = 8,
    parameter int CENTER       = 32768,
    parameter int ACQ_KP_SHIFT = 8,
    parameter int ACQ_KI_SHIFT = 6,
    parameter int KP_SHIFT     = 6,
    parameter int KI_SHIFT     = 2,
    parameter int INT_LIMIT    = 8388607,
    parameter int LOCK_WINDOW  = 256,
    parameter int LOCK_MAXERR  = 8,
    parameter int LOCK_GOOD    = 4
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    pi_loop_filter_if.slave lf
);

    localparam int SW     = CW_WIDTH + 2;
    localparam int WIN_W  = $clog2(LOCK_WINDOW);
    localparam int ERR_W  = $clog2(LOCK_MAXERR + 2);
    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);

    localparam logic signed [ACC_WIDTH:0] INT_HI    = (ACC_WIDTH + 1)'(INT_LIMIT);
    localparam logic signed [ACC_WIDTH:0] INT_LO    = -INT_HI;
    localparam logic signed [SW-1:0]      CW_MAX    = SW'((1 << CW_WIDTH) - 1);
    localparam logic signed [SW-1:0]      CW_CENTER = SW'(CENTER);
    localparam logic [WIN_W-1:0]          WIN_LAST  = WIN_W'(LOCK_WINDOW - 1);
    localparam logic [ERR_W-1:0]          ERR_SAT   = ERR_W'(LOCK_MAXERR + 1);
    localparam logic [ERR_W-1:0]          ERR_MAX   = ERR_W'(LOCK_MAXERR);
    localparam logic [GOOD_W-1:0]         GOOD_TGT  = GOOD_W'(LOCK_GOOD);

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } state_e;

    // Stage 1 state
    logic signed [ACC_WIDTH-1:0] integ_q, integ_d;
    logic signed [SW-1:0]        p_q, p_d;
    logic                        v1_q, v1_d;

    // Stage 2 / output state
    logic [CW_WIDTH-1:0] ctrl_word_q, ctrl_word_d;
    logic                ctrl_valid_q, ctrl_valid_d;
    logic                ctrl_sat_q, ctrl_sat_d;
    logic                locked_q, locked_d;

    // Lock detector state
    state_e              state_q, state_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;

    logic                        accept;
    logic [3:0]                  kp_sh, ki_sh;
    logic signed [ACC_WIDTH:0]   err_acc, integ_sum;
    logic signed [SW-1:0]        err_sw;
    logic signed [ACC_WIDTH-1:0] integ_int;
    logic signed [SW-1:0]        cw_sum;
    logic signed [SW-1:0]        dith_term;
    logic [ERR_W-1:0]            err_now;

    assign accept = lf.sample_en & ~lf.hold;

    // Gains follow the state in effect on the accept cycle.
    assign kp_sh = (state_q == ST_TRACK) ? 4'(KP_SHIFT) : 4'(ACQ_KP_SHIFT);
    assign ki_sh = (state_q == ST_TRACK) ? 4'(KI_SHIFT) : 4'(ACQ_KI_SHIFT);

    assign err_acc = {{(ACC_WIDTH - 3){lf.error_in[3]}}, lf.error_in};
    assign err_sw  = {{(SW - 4){lf.error_in[3]}}, lf.error_in};

`ifdef LF_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        dither_q, dither_d;

    always_comb begin
        lfsr_d   = lfsr_q;
        dither_d = dither_q;
        if (accept) begin
            dither_d = lfsr_q[0];
            lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            lfsr_q   <= 16'hACE1;
            dither_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            dither_q <= dither_d;
        end
    end

    always_comb begin
        dith_term    = '0;
        dith_term[0] = dither_q;
    end
`else
    assign dith_term = '0;
`endif

    // Stage 1: integrate at one extra bit so the clamp sees the true sum.
    always_comb begin
        // NOTE: every _d gets a default before any branch so no latch is inferred.
        integ_d   = integ_q;
        p_d       = p_q;
        v1_d      = accept;
        integ_sum = (ACC_WIDTH + 1)'(integ_q) + (err_acc <<< ki_sh);
        if (accept) begin
            if (integ_sum > INT_HI) begin
                integ_d = INT_HI[ACC_WIDTH-1:0];
            end else if (integ_sum < INT_LO) begin
                integ_d = INT_LO[ACC_WIDTH-1:0];
            end else begin
                integ_d = integ_sum[ACC_WIDTH-1:0];
            end
            p_d = err_sw <<< kp_sh;
        end
    end

    // Stage 2: combine paths and saturate into the unsigned control range.
    always_comb begin
        ctrl_word_d  = ctrl_word_q;
        ctrl_sat_d   = ctrl_sat_q;
        ctrl_valid_d = v1_q;
        integ_int    = integ_q >>> FRAC_BITS;
        cw_sum       = CW_CENTER + SW'(integ_int) + p_q + dith_term;
        if (v1_q) begin
            if (cw_sum < 0) begin
                ctrl_word_d = '0;
                ctrl_sat_d  = 1'b1;
            end else if (cw_sum > CW_MAX) begin
                ctrl_word_d = '1;
                ctrl_sat_d  = 1'b1;
            end else begin
                ctrl_word_d = cw_sum[CW_WIDTH-1:0];
                ctrl_sat_d  = 1'b0;
            end
        end
    end

    // Lock detector: judge each window of accepted samples by its nonzero-error count.
    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        err_cnt_d  = err_cnt_q;
        good_cnt_d = good_cnt_q;
        err_now    = err_cnt_q;
        if (lf.error_in != 4'sd0 && err_cnt_q != ERR_SAT) begin
            err_now = err_cnt_q + ERR_W'(1);
        end
        if (accept) begin
            if (win_cnt_q == WIN_LAST) begin
                win_cnt_d = '0;
                err_cnt_d = '0;
                if (err_now <= ERR_MAX) begin
                    if (good_cnt_q != GOOD_TGT) begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                    end
                    if (good_cnt_d == GOOD_TGT) begin
                        state_d = ST_TRACK;
                    end
                end else begin
                    good_cnt_d = '0;
                    state_d    = ST_ACQUIRE;
                end
            end else begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
                err_cnt_d = err_now;
            end
        end
        locked_d = (state_d == ST_TRACK);
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            integ_q      <= '0;
            p_q          <= '0;
            v1_q         <= 1'b0;
            ctrl_word_q  <= CENTER[CW_WIDTH-1:0];
            ctrl_valid_q <= 1'b0;
            ctrl_sat_q   <= 1'b0;
            locked_q     <= 1'b0;
            state_q      <= ST_ACQUIRE;
            win_cnt_q    <= '0;
            err_cnt_q    <= '0;
            good_cnt_q   <= '0;
        end else begin
            integ_q      <= integ_d;
            p_q          <= p_d;
            v1_q         <= v1_d;
            ctrl_word_q  <= ctrl_word_d;
            ctrl_valid_q <= ctrl_valid_d;
            ctrl_sat_q   <= ctrl_sat_d;
            locked_q     <= locked_d;
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            err_cnt_q    <= err_cnt_d;
            good_cnt_q   <= good_cnt_d;
        end
    end

    assign lf.ctrl_word  = ctrl_word_q;
    assign lf.ctrl_valid = ctrl_valid_q;
    assign lf.ctrl_sat   = ctrl_sat_q;
    assign lf.locked     = locked_q;

endmodule

// File: tb/tb_pi_loop_filter.sv
// Self-checking bench for pi_loop_filter: directed scenarios plus randomized error
// streams compared against an integer reference model of the filter and lock rules.
module tb_pi_loop_filter;

    localparam int CENTER    = 32768;
    localparam int INT_LIMIT = 8388607;
    localparam int CW_MAX    = 65535;

    logic sys_clk = 1'b0;
    logic rst_n;

    pi_loop_filter_if #(.CW_WIDTH(16)) lf ();

    pi_loop_filter dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .lf      (lf)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    // Reference model state
    int        m_integ;
    bit        m_trk;
    int        m_win, m_errs, m_good;
    bit        m_pend;
    int        m_pend_word;
    bit        m_pend_sat;
    int        m_word;
    bit        m_sat;
    bit        exp_valid;
    bit [15:0] m_lfsr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_integ  = 0;
        m_trk    = 1'b0;
        m_win    = 0;
        m_errs   = 0;
        m_good   = 0;
        m_pend   = 1'b0;
        m_word   = CENTER;
        m_sat    = 1'b0;
        m_lfsr   = 16'hACE1;
    endtask

    task automatic reset_cycles(input int n);
        rst_n        = 1'b0;
        lf.sample_en = 1'b1;
        lf.error_in  = 4'sd1;
        lf.hold      = 1'b0;
        model_reset();
        repeat (n) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            check("rst_word", lf.ctrl_word, CENTER);
            check("rst_valid", lf.ctrl_valid, 0);
            check("rst_sat", lf.ctrl_sat, 0);
            check("rst_locked", lf.locked, 0);
        end
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, predict, then compare after the edge.
    task automatic step(input bit en, input int err, input bit hld);
        int kp, ki, p, s;
        bit d;
        lf.sample_en = en;
        lf.error_in  = 4'(err);
        lf.hold      = hld;

        exp_valid = m_pend;
        if (m_pend) begin
            m_word = m_pend_word;
            m_sat  = m_pend_sat;
        end
        m_pend = 1'b0;

        if (en && !hld) begin
            kp = m_trk ? 6 : 8;
            ki = m_trk ? 2 : 6;
            m_integ = m_integ + err * (1 << ki);
            if (m_integ > INT_LIMIT)  m_integ = INT_LIMIT;
            if (m_integ < -INT_LIMIT) m_integ = -INT_LIMIT;
            p = err * (1 << kp);
            d = 1'b0;
`ifdef LF_DITHER_EN
            d = m_lfsr[0];
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
            s = CENTER + (m_integ >>> 8) + p + int'(d);
            m_pend_sat  = (s < 0) || (s > CW_MAX);
            m_pend_word = (s < 0) ? 0 : ((s > CW_MAX) ? CW_MAX : s);
            m_pend      = 1'b1;

            m_win++;
            if (err != 0) m_errs++;
            if (m_win == 256) begin
                if (m_errs <= 8) begin
                    m_good++;
                    if (m_good >= 4) m_trk = 1'b1;
                end else begin
                    m_good = 0;
                    m_trk  = 1'b0;
                end
                m_win  = 0;
                m_errs = 0;
            end
        end

        @(posedge sys_clk);
        @(negedge sys_clk);
        if (lf.ctrl_valid === 1'b1) n_pulses++;
        check("valid", lf.ctrl_valid, exp_valid);
        check("word", lf.ctrl_word, m_word);
        check("sat", lf.ctrl_sat, m_sat);
        check("locked", lf.locked, m_trk);
    endtask

    task automatic random_phase(input int cycles, input int err_pct, input int reset_at);
        int e;
        for (int i = 0; i < cycles; i++) begin
            if (i == reset_at) reset_cycles(2);
            e = 0;
            if ($urandom_range(0, 99) < err_pct) e = int'($urandom_range(0, 15)) - 8;
            step($urandom_range(0, 99) < 85, e, $urandom_range(0, 99) < 8);
        end
    endtask

    initial begin
        // Reset behaviour and first cycle after release
        reset_cycles(3);
        step(1'b1, 1, 1'b0);
        check("rel_word", lf.ctrl_word, CENTER);
        check("rel_valid", lf.ctrl_valid, 0);

        // ACQUIRE step response
        reset_cycles(2);
        n_pulses = 0;
        repeat (8) step(1'b1, 1, 1'b0);
        step(1'b0, 0, 1'b0);
        check("step_pulses", n_pulses, 8);
`ifndef LF_DITHER_EN
        check("step_word", lf.ctrl_word, 33026);
`endif

        // Lock acquisition, tracking gains, loss of lock
        reset_cycles(2);
        repeat (1023) step(1'b1, 0, 1'b0);
        check("lock_early", lf.locked, 0);
        step(1'b1, 0, 1'b0);
        check("lock_rise", lf.locked, 1);
        step(1'b1, 1, 1'b0);
        step(1'b0, 0, 1'b0);
`ifndef LF_DITHER_EN
        check("track_word", lf.ctrl_word, 32832);
`endif
        for (int i = 0; i < 255; i++) begin
            step(1'b1, (i < 8) ? 1 : 0, 1'b0);
            if (i == 253) check("lock_hold", lf.locked, 1);
        end
        check("lock_fall", lf.locked, 0);

        // Hold: in-flight sample completes, everything else freezes
        reset_cycles(2);
        repeat (4) step(1'b1, 7, 1'b0);
        n_pulses = 0;
        repeat (20) step(1'b1, -5, 1'b1);
        check("hold_pulses", n_pulses, 1);
        step(1'b1, 0, 1'b0);
        step(1'b0, 0, 1'b0);
`ifndef LF_DITHER_EN
        check("hold_integ", lf.ctrl_word, CENTER + 7);
`endif

        // Randomized streams: near-lock and noisy, with a mid-run reset
        reset_cycles(2);
        random_phase(1500, 1, 700);
        random_phase(1000, 25, -1);

        // Saturation high, integrator clamp, recovery
        reset_cycles(2);
        repeat (19000) step(1'b1, 7, 1'b0);
        step(1'b0, 0, 1'b0);
        check("sat_word", lf.ctrl_word, CW_MAX);
        check("sat_flag", lf.ctrl_sat, 1);
        repeat (30) step(1'b1, -8, 1'b0);
        step(1'b0, 0, 1'b0);
        check("sat_clear", lf.ctrl_sat, 0);

        // Zero error stream: dither pattern or a flat centre word
        reset_cycles(2);
        repeat (40) step(1'b1, 0, 1'b0);
`ifndef LF_DITHER_EN
        check("nodither_word", lf.ctrl_word, CENTER);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
